// File: rtl/imem_loader.sv
// Instruction memory loader: packs a checksummed little-endian byte stream into 32-bit
// word writes and holds the core in reset until a complete load has been verified.
module imem_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    StIdle, StHdr0, StHdr1, StData, StWrite, StChk, StDone, StError
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          chk_q, chk_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         words_q, words_d;
  logic [15:0]         new_len;
  logic                xfer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      chk_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      chk_q      <= chk_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
    end
  end

  // Moore outputs, decoded from the state register only.
  always_comb begin
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    core_reset = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state_q)
      StHdr0, StHdr1, StData, StChk: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      StWrite: begin
        wr_en = 1'b1;
        busy  = 1'b1;
      end
      StDone: begin
        done       = 1'b1;
        core_reset = 1'b0;
      end
      StError: error = 1'b1;
      default: ;
    endcase
  end

  assign wr_addr      = addr_q;
  assign wr_data      = word_q;
  assign words_loaded = words_q;
  assign xfer         = byte_valid && byte_ready;
  assign new_len      = {byte_data, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    chk_d      = chk_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    words_d    = words_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d    = StHdr0;
          chk_d      = '0;
          byte_idx_d = '0;
          addr_d     = '0;
          words_d    = '0;
        end
      end
      StHdr0: begin
        if (xfer) begin
          len_d[7:0] = byte_data;
          chk_d      = chk_q ^ byte_data;
          state_d    = StHdr1;
        end
      end
      StHdr1: begin
        if (xfer) begin
          len_d[15:8] = byte_data;
          chk_d       = chk_q ^ byte_data;
          if (new_len == 16'd0)          state_d = StChk;
          else if (32'(new_len) > DEPTH) state_d = StError;
          else                           state_d = StData;
        end
      end
      StData: begin
        if (xfer) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
          chk_d      = chk_q ^ byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        words_d = words_q + 16'd1;
        // Address stops at LEN-1 so it never wraps, even for a full-depth load.
        if (words_d == len_q) begin
          state_d = StChk;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StData;
        end
      end
      StChk: begin
        if (xfer) state_d = (byte_data == chk_q) ? StDone : StError;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
module tb_imem_loader;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready, wr_en, core_reset, busy, done, error;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [15:0]       words_loaded;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .core_reset  (core_reset),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]        stream_q[$];
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
  int                ready_in_write = 0;
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  bit                exp_done, exp_err;
  int                exp_words, exp_consumed;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && wr_en) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      if (byte_ready) ready_in_write++;
    end
  end

  // Reference: what a loader obeying the stream format should write and report.
  task automatic model();
    int         len;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    len = {stream_q[1], stream_q[0]};
    if (len > DEPTH) begin
      exp_done = 0; exp_err = 1; exp_words = 0; exp_consumed = 2;
      return;
    end
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(ADDR_W'(i));
      exp_data.push_back({stream_q[2+4*i+3], stream_q[2+4*i+2],
                          stream_q[2+4*i+1], stream_q[2+4*i]});
    end
    x = 8'h00;
    for (int j = 0; j < 2 + 4 * len; j++) x ^= stream_q[j];
    exp_done     = (x == stream_q[2+4*len]);
    exp_err      = !exp_done;
    exp_words    = len;
    exp_consumed = 3 + 4 * len;
  endtask

  task automatic build(input int len, input logic [7:0] corrupt);
    logic [7:0] x, b;
    stream_q.delete();
    stream_q.push_back(len[7:0]);
    stream_q.push_back(len[15:8]);
    if (len > DEPTH) return;
    x = len[7:0] ^ len[15:8];
    for (int i = 0; i < 4 * len; i++) begin
      b = 8'($urandom);
      stream_q.push_back(b);
      x ^= b;
    end
    stream_q.push_back(x ^ corrupt);
  endtask

  // Called and returns at a falling edge; byte_ready seen here governs the next rising edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int budget;
    gap    = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    budget = 0;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!byte_ready) check_eq("ready_timeout", byte_ready, 1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "/byte_ready"}, byte_ready, 0);
    check_eq({tag, "/wr_en"}, wr_en, 0);
    check_eq({tag, "/wr_addr"}, wr_addr, 0);
    check_eq({tag, "/wr_data"}, wr_data, 0);
    check_eq({tag, "/core_reset"}, core_reset, 1);
    check_eq({tag, "/busy"}, busy, 0);
    check_eq({tag, "/done"}, done, 0);
    check_eq({tag, "/error"}, error, 0);
    check_eq({tag, "/words"}, words_loaded, 0);
  endtask

  task automatic run_load(input string tag, input int max_gap, input int start_during);
    model();
    got_addr.delete();
    got_data.delete();
    ready_in_write = 0;
    pulse_start();
    check_eq({tag, "/busy_start"}, busy, 1);
    check_eq({tag, "/core_reset_start"}, core_reset, 1);
    for (int i = 0; i < exp_consumed; i++) begin
      if (i == start_during) pulse_start();
      send_byte(stream_q[i], max_gap);
    end
    check_eq({tag, "/done"}, done, exp_done);
    check_eq({tag, "/error"}, error, exp_err);
    repeat (3) @(negedge clk);
    check_eq({tag, "/done_hold"}, done, exp_done);
    check_eq({tag, "/core_reset"}, core_reset, !exp_done);
    check_eq({tag, "/busy"}, busy, 0);
    check_eq({tag, "/byte_ready"}, byte_ready, 0);
    check_eq({tag, "/words"}, words_loaded, exp_words);
    check_eq({tag, "/n_writes"}, got_addr.size(), exp_addr.size());
    check_eq({tag, "/ready_in_write"}, ready_in_write, 0);
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check_eq({tag, "/wr_addr"}, got_addr[i], exp_addr[i]);
      check_eq({tag, "/wr_data"}, got_data[i], exp_data[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);

    stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'hA0, 8'h00,
                 8'h33, 8'h05, 8'hB5, 8'h00, 8'h32};
    run_load("two_word", 0, -1);
    check_eq("two_word/word0", got_data.size() > 0 ? got_data[0] : 32'hx, 32'h00A00013);
    check_eq("two_word/word1", got_data.size() > 1 ? got_data[1] : 32'hx, 32'h00B50533);

    stream_q[10] = 8'h33;
    run_load("bad_chk", 0, -1);

    stream_q = '{8'h00, 8'h00, 8'h00};
    run_load("empty", 0, -1);

    stream_q = '{8'h41, 8'h00};
    run_load("oversize", 0, -1);

    stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'hA0, 8'h00,
                 8'h33, 8'h05, 8'hB5, 8'h00, 8'h32};
    run_load("flow", 3, 3);

    // Reset asserted between clock edges must take effect without a clock.
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(stream_q[i], 0);
    #2 reset = 1'b0;
    #1 check_reset_vals("mid_reset");
    @(negedge clk);
    check_reset_vals("mid_reset_hold");
    reset = 1'b1;
    @(negedge clk);
    run_load("after_reset", 1, -1);

    build(64, 8'h00);
    run_load("full_depth", 0, -1);
    build(256, 8'h00);
    run_load("len_hi_byte", 0, -1);

    for (int k = 0; k < 12; k++) begin
      int         len;
      logic [7:0] corrupt;
      len     = ($urandom_range(5, 0) == 0) ? int'($urandom_range(1000, 65))
                                            : int'($urandom_range(8, 0));
      corrupt = ($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      build(len, corrupt);
      run_load("random", int'($urandom_range(3, 0)), int'($urandom_range(12, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: takes a byte stream over a valid/ready handshake, packs it into 32-bit words and issues one-cycle word writes into the instruction memory.
- Holds the core in reset until a complete load has been checksum-verified.
- Sits between a host byte source (UART receiver or bench) and the instruction memory write port / core reset.

Parameters:
- DEPTH, 64, number of 32-bit instruction words in the target memory.
- ADDR_W, 6, width of the word address, clog2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting it (low) immediately forces all state and outputs to their reset values.
- start  in  1  one-cycle request to begin a load.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction memory word write strobe.
- wr_addr  out  ADDR_W  word address of the write.
- wr_data  out  32  word to write.
- core_reset  out  1  active-high reset to the core.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully.
- error  out  1  last load failed.
- words_loaded  out  16  number of words written in the current or last load.

Behaviour:
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_reset=1, busy=0, done=0, error=0, words_loaded=0; FSM in IDLE. Reset mid-load abandons the load; no further writes occur.
- Byte transfer occurs on a rising edge where byte_valid && byte_ready.
- byte_ready, wr_en, core_reset, busy, done and error are Moore outputs decoded from the state register. There is no combinational path from any input to any output.
- Stream format, little-endian throughout:
  - LEN low byte, then LEN high byte;
  - LEN×4 data bytes, first byte to wr_data[7:0];
  - one checksum byte equal to the XOR of all preceding bytes, header included.
- States:
  - IDLE: byte_ready=0, core_reset=1. On start, go to HDR0. Clear the checksum accumulator, byte index, word address, words_loaded, done and error.
  - HDR0: byte_ready=1. On transfer, LEN[7:0] ← byte; go to HDR1.
  - HDR1: byte_ready=1. On transfer, LEN[15:8] ← byte. Then:
    - LEN==0 → CHK;
    - LEN>DEPTH → ERROR;
    - otherwise → DATA.
  - DATA: byte_ready=1. On transfer, store the byte into lane byte_idx (0..3) of the word register and increment byte_idx. On the transfer with byte_idx==3, go to WRITE and wrap byte_idx to 0.
  - WRITE: byte_ready=0; wr_en=1 for exactly one cycle with wr_addr=word address and wr_data=assembled word. Next cycle: word address +1 and words_loaded +1. If the new count == LEN → CHK, else → DATA.
  - CHK: byte_ready=1. On transfer, compare the byte with the accumulator: match → DONE, mismatch → ERROR.
  - DONE: done=1, core_reset=0, busy=0, byte_ready=0.
  - ERROR: error=1, core_reset=1, busy=0, byte_ready=0.
- busy=1 in HDR0, HDR1, DATA, WRITE and CHK.
- start is honoured only in IDLE, DONE or ERROR, and restarts at HDR0 with core_reset=1 re-asserted. start is ignored in busy states.
- The accumulator XORs every transferred header and data byte. The checksum byte itself is not accumulated.
- Minimum throughput: 5 cycles per word (4 transfers + WRITE). byte_valid may drop at any time with no effect other than a stall.
- Words already written before an ERROR stay written; the loader does not roll back.
- The word address never exceeds LEN-1 ≤ DEPTH-1, so there is no wrap.

Test Plan:
- Two-word load: release reset, pulse start, send bytes 02 00 13 00 A0 00 33 05 B5 00 32 with byte_valid held high → wr_en pulse at addr 0 with 0x00A00013, then at addr 1 with 0x00B50533; done=1, core_reset=0, words_loaded=2, error=0.
- Bad checksum: same stream with last byte 0x33 → both writes still occur; error=1, core_reset stays 1, done=0.
- Empty program: start, bytes 00 00 00 → no wr_en; done=1, core_reset=0, words_loaded=0.
- Oversize length: start, bytes 41 00 (LEN=65) → error=1 one cycle after the second byte, byte_ready=0 thereafter, no wr_en.
- Flow control: in the two-word load, drop byte_valid for 3 cycles between bytes, and hold byte_valid high through WRITE → byte_ready=0 in WRITE, no byte lost or duplicated, same write data as the two-word case. A start pulse during DATA is ignored.
- Reset mid-load: drive reset low after the 6th byte of the two-word stream → all outputs take reset values immediately with core_reset=1. After reset is released, a full two-word load completes correctly.
